// File: rtl/adc_resp_pkg.sv
// Shared types and helpers for the LTC2308-style SPI ADC responder.
// Holds the FSM state enum, config-word bit positions, the power-on config,
// and the small helpers that map config fields to a channel and apply the
// output code format.
package adc_resp_pkg;

    // Result width the helpers below are written for.
    localparam int RES_W = 12;

    // Responder FSM states.
    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        CONVERT   = 2'd3
    } state_t;

    // Config word layout {S/D, O/S, S1, S0, UNI, SLP}.
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    // Single-ended, channel 0, unipolar, awake.
    localparam logic [5:0] CFG_RESET = 6'b100010;

    // Mid-scale code used to turn straight binary into two's complement.
    localparam logic [RES_W-1:0] MID_CODE = 12'h800;

    // {O/S,S1,S0} -> single-ended channel number {S1,S0,O/S}.
    function automatic logic [2:0] ch_index(input logic [2:0] os_s1_s0);
        return {os_s1_s0[1:0], os_s1_s0[2]};
    endfunction

    // Unipolar keeps straight binary; bipolar flips the MSB so mid-scale reads 0.
    function automatic logic [RES_W-1:0] apply_uni(input logic [RES_W-1:0] sample,
                                                   input logic             uni);
        return uni ? sample : (sample ^ MID_CODE);
    endfunction

endpackage

// File: rtl/adc_spi_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall pulses.
// The reset value is selectable so a line can be held at its "not yet
// proven" level until real samples arrive from the pin.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw input through the synchronizer chain and keep the last
    // synchronized value for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Level and single-cycle edge pulses on the synchronized value.
    always_comb begin
        level = sync_q[STAGES-1];
        rise  = sync_q[STAGES-1] & ~prev_q;
        fall  = ~sync_q[STAGES-1] & prev_q;
    end

endmodule

// File: rtl/adc_spi_responder.sv
// Device end of an LTC2308-style 4-wire serial ADC (CS_N/SCLK/DIN/DOUT).
// A master frame shifts out the previous conversion result MSB first on
// DOUT while a 6-bit config word is shifted in on DIN; cs_n rising starts
// the next conversion, which uses the config just accepted.
//
// SPI framing: cs_n low opens a frame; DOUT changes after each detected
// sclk fall so the master samples it while sclk is low or on the next rise;
// DIN is sampled on detected sclk rises. Every SCLK phase must last at least
// SYNC_STAGES+1 clock cycles.
//
// Optional build macro ADC_RESP_TEST_RAMP_EN: ignore ch_data and serve
// channel k as (k*512 + ramp), ramp counting completed conversions.
module adc_spi_responder
    import adc_resp_pkg::*;
#(
    parameter int DATA_W       = 12,
    parameter int CFG_W        = 6,
    parameter int SYNC_STAGES  = 2,
    parameter int TCONV_CYCLES = 80
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                adc_cs_n,
    input  logic                adc_sclk,
    input  logic                adc_din,
    output logic                adc_dout,
    input  logic [8*DATA_W-1:0] ch_data,
    output logic [CFG_W-1:0]    cfg_out,
    output logic                busy,
    output logic                frame_done,
    output logic                protocol_err,
    output state_t              dbg_state
);

    localparam int          CW        = $clog2(TCONV_CYCLES);
    localparam logic [CW-1:0] CONV_LAST = CW'(TCONV_CYCLES - 1);
    localparam logic [3:0]  NBITS     = 4'(DATA_W);
    localparam logic [3:0]  CFG_BITS  = 4'(CFG_W);
    localparam logic signed [DATA_W:0] BI_MAX = (DATA_W+1)'((1 << (DATA_W-1)) - 1);
    localparam logic signed [DATA_W:0] BI_MIN = -BI_MAX;

    // Synchronized link signals.
    logic cs_s, cs_rise, cs_fall;
    logic sclk_rise, sclk_fall;
    logic din_s;

    // State and datapath registers.
    state_t              state, state_nx;
    logic [CW-1:0]       conv_cnt;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   result;
    logic [CFG_W-1:0]    cfg_sr;
    logic [3:0]          fall_cnt;
    logic [3:0]          rise_cnt;
    logic                asleep_q;

    // Conversion datapath.
    logic [DATA_W-1:0]       samples [8];
    logic [DATA_W-1:0]       op_a, op_b;
    logic signed [DATA_W:0]  diff;
    logic [DATA_W-1:0]       diff_code;
    logic [DATA_W-1:0]       conv_value;
    logic [2:0]              se_ch;

    // cs_n is held low through reset so a frame still in progress when reset
    // releases is not mistaken for idle; WAIT_HIGH then needs a real high.
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clock (clock),
        .reset (reset),
        .d     (adc_cs_n),
        .level (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clock (clock),
        .reset (reset),
        .d     (adc_sclk),
        .level (),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clock (clock),
        .reset (reset),
        .d     (adc_din),
        .level (din_s),
        .rise  (),
        .fall  ()
    );

`ifdef ADC_RESP_TEST_RAMP_EN
    logic [DATA_W-1:0] ramp_q;
    logic              unused_ch_data;

    assign unused_ch_data = ^ch_data;

    // Ramp advances once per completed conversion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ramp_q <= '0;
        end else if (state == CONVERT && conv_cnt == CONV_LAST) begin
            ramp_q <= ramp_q + 1'b1;
        end
    end

    // Channel k reads k*512 above the ramp, wrapping at full scale.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            samples[k] = DATA_W'(k << (DATA_W - 3)) + ramp_q;
        end
    end
`else
    // Channel k comes straight from its slice of ch_data.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            samples[k] = ch_data[k*DATA_W +: DATA_W];
        end
    end
`endif

    // Compute the conversion value the current cfg_out asks for.
    always_comb begin
        se_ch = ch_index({cfg_out[CFG_OS], cfg_out[CFG_S1], cfg_out[CFG_S0]});
        op_a  = samples[{cfg_out[CFG_S1], cfg_out[CFG_S0], 1'b0}];
        op_b  = samples[{cfg_out[CFG_S1], cfg_out[CFG_S0], 1'b1}];
        if (cfg_out[CFG_OS]) begin
            op_a = samples[{cfg_out[CFG_S1], cfg_out[CFG_S0], 1'b1}];
            op_b = samples[{cfg_out[CFG_S1], cfg_out[CFG_S0], 1'b0}];
        end
        diff = $signed({1'b0, op_a}) - $signed({1'b0, op_b});
        // Differential: unipolar clamps below zero, bipolar saturates and is
        // already a two's complement code.
        if (cfg_out[CFG_UNI]) begin
            diff_code = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
        end else if (diff > BI_MAX) begin
            diff_code = BI_MAX[DATA_W-1:0];
        end else if (diff < BI_MIN) begin
            diff_code = BI_MIN[DATA_W-1:0];
        end else begin
            diff_code = diff[DATA_W-1:0];
        end
        if (cfg_out[CFG_SD]) begin
            conv_value = apply_uni(samples[se_ch], cfg_out[CFG_UNI]);
        end else begin
            conv_value = diff_code;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= WAIT_HIGH;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and busy flag.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            WAIT_HIGH: if (cs_s) state_nx = IDLE;
            IDLE:      if (cs_fall) state_nx = SHIFT;
            SHIFT:     if (cs_rise) state_nx = CONVERT;
            CONVERT: begin
                busy = 1'b1;
                // A frame opened during conversion must close before the next one counts.
                if (conv_cnt == CONV_LAST) state_nx = cs_s ? IDLE : WAIT_HIGH;
            end
            default:   state_nx = WAIT_HIGH;
        endcase
    end

    // DOUT: MSB as soon as the frame opens, then the shift register until all
    // result bits have gone out; zero whenever no valid frame is being served.
    always_comb begin
        adc_dout = 1'b0;
        if (state == SHIFT && fall_cnt < NBITS) begin
            adc_dout = shift_reg[DATA_W-1];
        end else if (state == IDLE && cs_fall) begin
            adc_dout = result[DATA_W-1];
        end
    end

    assign dbg_state = state;

    // Frame shifting, config capture, conversion capture and status pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg    <= '0;
            result       <= '0;
            cfg_sr       <= '0;
            cfg_out      <= CFG_RESET;
            fall_cnt     <= '0;
            rise_cnt     <= '0;
            conv_cnt     <= '0;
            asleep_q     <= 1'b0;
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        shift_reg <= result;
                        fall_cnt  <= '0;
                        rise_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_fall && fall_cnt < NBITS) begin
                        shift_reg <= shift_reg << 1;
                        fall_cnt  <= fall_cnt + 1'b1;
                    end
                    if (sclk_rise) begin
                        if (rise_cnt < CFG_BITS) cfg_sr <= {cfg_sr[CFG_W-2:0], din_s};
                        if (rise_cnt != 4'hF)    rise_cnt <= rise_cnt + 1'b1;
                    end
                    if (cs_rise) begin
                        conv_cnt <= '0;
                        if (rise_cnt >= CFG_BITS) begin
                            cfg_out    <= cfg_sr;
                            frame_done <= 1'b1;
                        end else begin
                            protocol_err <= 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    if (cs_fall) protocol_err <= 1'b1;
                    if (conv_cnt == '0) begin
                        // Sleep forces zero for the sleeping config and for the
                        // first conversion after waking.
                        result   <= (cfg_out[CFG_SLP] || asleep_q) ? '0 : conv_value;
                        asleep_q <= cfg_out[CFG_SLP];
                    end
                    if (conv_cnt != CONV_LAST) conv_cnt <= conv_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;
    import adc_resp_pkg::*;

    localparam int PH = 5;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        adc_cs_n = 1'b1;
    logic        adc_sclk = 1'b0;
    logic        adc_din  = 1'b0;
    logic        adc_dout;
    logic [95:0] ch_data;
    logic [5:0]  cfg_out;
    logic        busy, frame_done, protocol_err;
    state_t      dbg_state;

    int checks = 0, errors = 0;
    int fd_cnt = 0, pe_cnt = 0, busy_run = 0, last_busy = 0;
    int exp_fd = 0, exp_pe = 0;
    logic [11:0] exp_q[$];
    int          exp_n_q[$];

    // Clock and watchdog.
    always #10 clock = ~clock;

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    adc_spi_responder dut (
        .clock        (clock),
        .reset        (reset),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .adc_din      (adc_din),
        .adc_dout     (adc_dout),
        .ch_data      (ch_data),
        .cfg_out      (cfg_out),
        .busy         (busy),
        .frame_done   (frame_done),
        .protocol_err (protocol_err),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Pulse counters and busy run length.
    always @(negedge clock) begin
        if (frame_done === 1'b1)   fd_cnt++;
        if (protocol_err === 1'b1) pe_cnt++;
        if (busy === 1'b1) busy_run++;
        else begin
            if (busy_run != 0) last_busy = busy_run;
            busy_run = 0;
        end
    end

    // Monitor: collect DOUT before each sclk fall, compare at cs_n rise.
    initial begin : monitor
        logic [11:0] got;
        logic [11:0] e;
        int n, en;
        forever begin
            @(negedge adc_cs_n);
            got = '0;
            n = 0;
            forever begin
                @(negedge adc_sclk or posedge adc_cs_n);
                if (adc_cs_n) break;
                got = {got[10:0], adc_dout};
                n++;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected: got %0h, expected no frame", got);
            end else begin
                e  = exp_q.pop_front();
                en = exp_n_q.pop_front();
                check("frame_bits", n, en);
                check("frame_dout", got, e >> (12 - en));
            end
        end
    end

    // Driver: one master frame; optional reset after rst_at sclk pulses.
    task automatic frame(input logic [5:0] cfg, input int npulse,
                         input logic [11:0] exp, input int rst_at);
        exp_q.push_back(exp);
        exp_n_q.push_back(npulse);
        @(negedge clock);
        adc_cs_n = 1'b0;
        repeat (4) @(negedge clock);
        for (int i = 0; i < npulse; i++) begin
            adc_din = (i < 6) ? cfg[5-i] : 1'b0;
            repeat (2) @(negedge clock);
            adc_sclk = 1'b1;
            repeat (PH) @(negedge clock);
            adc_sclk = 1'b0;
            repeat (PH) @(negedge clock);
            if (i + 1 == rst_at) begin
                reset = 1'b0;
                #1;
                check("dout_in_reset", adc_dout, 0);
                check("state_in_reset", dbg_state, WAIT_HIGH);
                check("cfg_in_reset", cfg_out, 6'b100010);
                repeat (3) @(negedge clock);
                reset = 1'b1;
                repeat (2) @(negedge clock);
            end
        end
        adc_din = 1'b0;
        repeat (4) @(negedge clock);
        adc_cs_n = 1'b1;
    endtask

    // Let the conversion start and finish, with a bounded wait.
    task automatic settle();
        int k;
        k = 0;
        repeat (6) @(negedge clock);
        while (busy !== 1'b0 && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=%0b, expected 0", busy);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic normal(input logic [5:0] cfg, input logic [11:0] exp);
        frame(cfg, 12, exp, 0);
        settle();
        exp_fd++;
        check("frame_done_count", fd_cnt, exp_fd);
        check("protocol_err_count", pe_cnt, exp_pe);
        check("cfg_out", cfg_out, cfg);
    endtask

    initial begin
        ch_data = '0;
        ch_data[0*12 +: 12] = 12'hA5C;
        ch_data[1*12 +: 12] = 12'h111;
        ch_data[3*12 +: 12] = 12'h123;
        ch_data[7*12 +: 12] = 12'h7E1;

        #1 reset = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_cfg_out", cfg_out, 6'b100010);
        check("rst_busy", busy, 0);
        check("rst_dout", adc_dout, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_protocol_err", protocol_err, 0);
        check("rst_state", dbg_state, WAIT_HIGH);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("state_after_reset", dbg_state, IDLE);

        normal(6'b100010, 12'h000);   // result register still reset
        normal(6'b110110, 12'hA5C);   // ch0 from frame 1 config
        normal(6'b110100, 12'h123);   // ch3 unipolar
        normal(6'b100010, 12'h923);   // ch3 bipolar

        // Short frame: 4 pulses, then a frame opened during conversion.
        frame(6'b111111, 4, 12'hA5C, 0);
        repeat (10) @(negedge clock);
        exp_pe++;
        check("short_protocol_err", pe_cnt, exp_pe);
        check("short_cfg_kept", cfg_out, 6'b100010);
        check("short_busy", busy, 1);
        frame(6'b110110, 12, 12'h000, 0);
        settle();
        exp_pe++;
        check("early_protocol_err", pe_cnt, exp_pe);
        check("busy_length", last_busy, 80);
        check("early_frame_done", fd_cnt, exp_fd);
        check("early_cfg_kept", cfg_out, 6'b100010);
        check("early_state", dbg_state, IDLE);

        normal(6'b111110, 12'hA5C);   // conversion from the short frame (ch0)
        normal(6'b100011, 12'h7E1);   // ch7, then sleep
        normal(6'b100010, 12'h000);   // asleep
        normal(6'b000010, 12'h000);   // waking conversion still zero
        normal(6'b010010, 12'h94B);   // diff ch0-ch1 unipolar
        normal(6'b000000, 12'h000);   // swapped, clamped
        normal(6'b010000, 12'h7FF);   // diff bipolar +sat
        normal(6'b100010, 12'h801);   // swapped bipolar -sat

        // Reset after 5 bits while cs_n stays low.
        frame(6'b100010, 12, 12'hA00, 5);
        repeat (10) @(negedge clock);
        check("reset_frame_done", fd_cnt, exp_fd);
        check("reset_busy", busy, 0);
        check("reset_state_idle", dbg_state, IDLE);
        check("reset_cfg_out", cfg_out, 6'b100010);

        normal(6'b100010, 12'h000);   // result reset to 0

        repeat (5) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
